// File: rtl/alu_wb_stage.sv
// ALU writeback stage: in-order result FIFO draining into the register file, plus the architectural flag register.
// Optional ALU_WB_BYPASS_EN adds a combinational forwarding lookup (byp_addr/byp_hit/byp_data) over pending entries.
module alu_wb_stage #(
  parameter int DEPTH = 2,
  parameter int AW    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_rslt,
  input  logic                     in_sc,
  input  logic                     in_zero,
  input  logic                     in_pari,
  input  logic                     in_neq,
  input  logic [AW-1:0]            in_addr,
  input  logic                     in_we,
  input  logic                     in_flag_en,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [7:0]               wb_data,
  output logic [AW-1:0]            wb_addr,
  output logic                     wb_we,
  output logic                     flag_c,
  output logic                     flag_z,
  output logic                     flag_p,
  output logic                     flag_neq,
  output logic [$clog2(DEPTH):0]   occupancy,
`ifdef ALU_WB_BYPASS_EN
  input  logic [AW-1:0]            byp_addr,
  output logic                     byp_hit,
  output logic [7:0]               byp_data,
`endif
  output logic [15:0]              retire_cnt
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [7:0]    data;
    logic [AW-1:0] addr;
    logic          we;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, push, pop;

  assign full     = (count == (PW+1)'(DEPTH));
  // Gating with rst_n keeps in_ready low while reset is held; no wb_ready term.
  assign in_ready = rst_n & ~full & ~flush;
  assign push     = in_valid & in_ready;
  assign wb_valid = (count != '0);
  assign pop      = wb_valid & wb_ready;

  assign wb_data   = mem[rd_ptr].data;
  assign wb_addr   = mem[rd_ptr].addr;
  assign wb_we     = wb_valid & mem[rd_ptr].we;
  assign occupancy = count;

  // Entry storage needs no reset: nothing is visible unless count covers it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: in_rslt, addr: in_addr, we: in_we};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      retire_cnt <= '0;
      flag_c     <= 1'b0;
      flag_z     <= 1'b0;
      flag_p     <= 1'b0;
      flag_neq   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
        if (pop) retire_cnt <= retire_cnt + 16'd1;
      end
      // Flags move at push so the very next ALU op sees the new carry.
      if (push && in_flag_en) begin
        flag_c   <= in_sc;
        flag_z   <= in_zero;
        flag_p   <= in_pari;
        flag_neq <= in_neq;
      end
    end
  end

`ifdef ALU_WB_BYPASS_EN
  logic [PW-1:0] idx;
  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = 8'h00;
    idx      = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (((PW+1)'(i) < count) && mem[idx].we && (mem[idx].addr == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = mem[idx].data;
      end
    end
  end
`endif
endmodule
